window_scan_ctrl: RTL and testbench

- Frame sequencer for the 5x5 line-buffer and Sobel window datapath.
- Tracks incoming pixel coordinates from the VGA pixel strobe and gates line-buffer shifting.
- Clears the buffers across vertical sync.
- Produces a window-valid flag and centre-pixel coordinates aligned to the Sobel/feature pipeline output, and signals end-of-frame after the pipeline has drained.

---
 rtl/window_scan_ctrl.sv | 161 ++++++++++++++++
 tb/tb_window_scan_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_scan_ctrl.sv
// Frame sequencer for the 5x5 line-buffer / Sobel window datapath: pixel coordinate
// tracking, buffer shift/clear control, result alignment and end-of-frame signalling.
module window_scan_ctrl #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned WIN      = 5,
    parameter int unsigned PIPE_LAT = 2,
    parameter int unsigned XW       = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          VGA_VS,
    input  logic          pix_valid,
    output logic          shift_en,
    output logic          buf_clear,
    output logic          win_valid,
    output logic [XW-1:0] center_x,
    output logic [XW-1:0] center_y,
    output logic          busy,
    output logic          frame_done,
    output logic          err_short,
    output logic          err_extra
);

    localparam int unsigned DW = (PIPE_LAT < 1) ? 1 : $clog2(PIPE_LAT + 1);
    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [XW-1:0] Y_LAST = XW'(V_ACTIVE - 1);
    localparam logic [XW-1:0] W_EDGE = XW'(WIN - 1);
    localparam logic [XW-1:0] W_HALF = XW'((WIN - 1) / 2);
    localparam logic [DW-1:0] DRAIN_INIT = DW'(PIPE_LAT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t          state, state_d;
    logic [XW-1:0]   x, y, x_d, y_d;
    logic [DW-1:0]   cnt, cnt_d;
    logic            vs_q;
    logic            vs_rise, vs_fall;
    logic            accept, flush, set_short, set_extra, done_d, win_new;
    logic [PIPE_LAT-1:0] pv;
    logic [XW-1:0]   pcx [PIPE_LAT];
    logic [XW-1:0]   pcy [PIPE_LAT];

    assign vs_rise = !vs_q && VGA_VS;
    assign vs_fall = vs_q && !VGA_VS;

    // Next-state, coordinate and event decode
    always_comb begin
        state_d   = state;
        x_d       = x;
        y_d       = y;
        cnt_d     = cnt;
        accept    = 1'b0;
        flush     = 1'b0;
        set_short = 1'b0;
        set_extra = 1'b0;
        done_d    = 1'b0;
        case (state)
            IDLE: begin
                if (vs_rise) begin
                    state_d = ACTIVE;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            ACTIVE: begin
                if (vs_fall) begin
                    // Abort beats a coincident pixel
                    state_d   = IDLE;
                    set_short = 1'b1;
                    flush     = 1'b1;
                    x_d       = '0;
                    y_d       = '0;
                end else if (pix_valid) begin
                    accept = 1'b1;
                    if (x == X_LAST) begin
                        x_d = '0;
                        if (y == Y_LAST) begin
                            y_d     = '0;
                            state_d = DRAIN;
                            cnt_d   = DRAIN_INIT;
                        end else begin
                            y_d = y + XW'(1);
                        end
                    end else begin
                        x_d = x + XW'(1);
                    end
                end
            end
            DRAIN: begin
                set_extra = pix_valid;
                if (vs_fall) begin
                    state_d = IDLE;
                end else if (cnt == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt - DW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign win_new = accept && (x >= W_EDGE) && (y >= W_EDGE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            cnt        <= '0;
            vs_q       <= 1'b1;
            shift_en   <= 1'b0;
            buf_clear  <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            err_short  <= 1'b0;
            err_extra  <= 1'b0;
            win_valid  <= 1'b0;
            center_x   <= '0;
            center_y   <= '0;
            pv         <= '0;
            for (int i = 0; i < int'(PIPE_LAT); i++) begin
                pcx[i] <= '0;
                pcy[i] <= '0;
            end
        end else begin
            state      <= state_d;
            x          <= x_d;
            y          <= y_d;
            cnt        <= cnt_d;
            vs_q       <= VGA_VS;
            shift_en   <= accept;
            buf_clear  <= !VGA_VS || (state == IDLE);
            busy       <= (state_d != IDLE);
            frame_done <= done_d;
            err_short  <= err_short | set_short;
            err_extra  <= err_extra | set_extra;
            // Alignment chain: window valid and centre travel with the datapath
            pv[0]  <= win_new;
            pcx[0] <= x - W_HALF;
            pcy[0] <= y - W_HALF;
            for (int i = 1; i < int'(PIPE_LAT); i++) begin
                pv[i]  <= pv[i-1] && !flush;
                pcx[i] <= pcx[i-1];
                pcy[i] <= pcy[i-1];
            end
            win_valid <= pv[PIPE_LAT-1] && !flush;
            if (pv[PIPE_LAT-1] && !flush) begin
                center_x <= pcx[PIPE_LAT-1];
                center_y <= pcy[PIPE_LAT-1];
            end
        end
    end

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Scoreboard bench for window_scan_ctrl on an 8x6 frame with a 5x5 window.
module tb_window_scan_ctrl;

    localparam int H  = 8;
    localparam int V  = 6;
    localparam int W  = 5;
    localparam int PL = 2;
    localparam int XW = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          VGA_VS = 1'b1;
    logic          pix_valid = 1'b0;
    logic          shift_en, buf_clear, win_valid, busy, frame_done, err_short, err_extra;
    logic [XW-1:0] center_x, center_y;

    window_scan_ctrl #(
        .H_ACTIVE(H), .V_ACTIVE(V), .WIN(W), .PIPE_LAT(PL), .XW(XW)
    ) dut (
        .clk(clk), .reset(reset), .VGA_VS(VGA_VS), .pix_valid(pix_valid),
        .shift_en(shift_en), .buf_clear(buf_clear), .win_valid(win_valid),
        .center_x(center_x), .center_y(center_y), .busy(busy),
        .frame_done(frame_done), .err_short(err_short), .err_extra(err_extra)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int cx;
        int cy;
    } exp_t;

    exp_t wq[$];
    int   sq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Monitor statistics
    bit   mon_en = 1'b0;
    int   n_win = 0, n_shift = 0, n_fd = 0;
    int   fd_cyc = -1, first_win_cyc = -1, last_win_cyc = -1;
    int   first_cx = -1, first_cy = -1, last_cx = -1, last_cy = -1;
    logic fd_busy = 1'b1;

    // Bench-side frame model
    bit   m_active = 1'b0;
    bit   m_vsq = 1'b1;
    int   mx = 0, my = 0;
    int   drain_end = 0, last_acc = 0, acc44 = 0;

    // Drive one cycle of inputs and record what the DUT must produce for them
    task automatic tick(input logic pv, input logic vs);
        int   e;
        exp_t ex;
        pix_valid = pv;
        VGA_VS    = vs;
        e = cyc + 1;
        if (m_active) begin
            if (m_vsq && !vs) begin
                m_active = 1'b0;
                mx = 0;
                my = 0;
                while (wq.size() > 0 && wq[$].cyc >= e) void'(wq.pop_back());
            end else if (pv) begin
                sq.push_back(e);
                if (mx == 4 && my == 4) acc44 = e;
                if (mx >= W - 1 && my >= W - 1) begin
                    ex.cyc = e + PL;
                    ex.cx  = mx - (W - 1) / 2;
                    ex.cy  = my - (W - 1) / 2;
                    wq.push_back(ex);
                end
                last_acc = e;
                if (mx == H - 1) begin
                    mx = 0;
                    if (my == V - 1) begin
                        my = 0;
                        m_active = 1'b0;
                        drain_end = e + PL + 1;
                    end else begin
                        my++;
                    end
                end else begin
                    mx++;
                end
            end
        end else if (!m_vsq && vs && e > drain_end) begin
            m_active = 1'b1;
            mx = 0;
            my = 0;
        end
        m_vsq = vs;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic pv);
        int e;
        e = cyc + 1;
        reset     = 1'b1;
        pix_valid = pv;
        while (sq.size() > 0 && sq[$] >= e) void'(sq.pop_back());
        while (wq.size() > 0 && wq[$].cyc >= e) void'(wq.pop_back());
        m_active = 1'b0;
        m_vsq    = 1'b1;
        mx = 0;
        my = 0;
        @(posedge clk);
        #1;
    endtask

    // Per-cycle checks of shift_en and the win_valid/centre scoreboard
    task automatic monitor();
        bit   exp_sh;
        exp_t ex;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                exp_sh = (sq.size() > 0 && sq[0] == cyc);
                if (exp_sh) void'(sq.pop_front());
                n_cmp++;
                if (shift_en !== exp_sh) begin
                    n_bad++;
                    $display("FAIL shift_en cyc=%0d got=%b want=%b", cyc, shift_en, exp_sh);
                end
                if (shift_en === 1'b1) n_shift++;
                while (wq.size() > 0 && wq[0].cyc < cyc) begin
                    ex = wq.pop_front();
                    n_cmp++;
                    n_bad++;
                    $display("FAIL win_missing cyc=%0d got=none want=(%0d,%0d)@%0d",
                             cyc, ex.cx, ex.cy, ex.cyc);
                end
                if (win_valid === 1'b1) begin
                    n_win++;
                    if (first_win_cyc < 0) begin
                        first_win_cyc = cyc;
                        first_cx = int'(center_x);
                        first_cy = int'(center_y);
                    end
                    last_win_cyc = cyc;
                    last_cx = int'(center_x);
                    last_cy = int'(center_y);
                    n_cmp++;
                    if (wq.size() == 0) begin
                        n_bad++;
                        $display("FAIL win_unexpected cyc=%0d got=(%0d,%0d) want=none",
                                 cyc, center_x, center_y);
                    end else begin
                        ex = wq.pop_front();
                        if (ex.cyc != cyc || center_x !== 10'(ex.cx) || center_y !== 10'(ex.cy)) begin
                            n_bad++;
                            $display("FAIL win_result got=(%0d,%0d)@%0d want=(%0d,%0d)@%0d",
                                     center_x, center_y, cyc, ex.cx, ex.cy, ex.cyc);
                        end
                    end
                end
                if (frame_done === 1'b1) begin
                    n_fd++;
                    fd_cyc  = cyc;
                    fd_busy = busy;
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        VGA_VS = 1'b1;
        pix_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        n_cmp++;
        if ({shift_en, buf_clear, win_valid, busy, frame_done, err_short, err_extra} !== 7'b0100000) begin
            n_bad++;
            $display("FAIL reset_flags got=%b want=0100000",
                     {shift_en, buf_clear, win_valid, busy, frame_done, err_short, err_extra});
        end
        n_cmp++;
        if (center_x !== '0 || center_y !== '0) begin
            n_bad++;
            $display("FAIL reset_center got=(%0d,%0d) want=(0,0)", center_x, center_y);
        end
        reset  = 1'b0;
        m_vsq  = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic test_idle_ignore();
        repeat (5) tick(1'b1, 1'b1);
        @(negedge clk);
        n_cmp++;
        if ({busy, buf_clear, shift_en} !== 3'b010) begin
            n_bad++;
            $display("FAIL idle_ignore got busy/clr/shift=%b want=010", {busy, buf_clear, shift_en});
        end
        n_cmp++;
        if (n_shift != 0) begin
            n_bad++;
            $display("FAIL idle_shift_count got=%0d want=0", n_shift);
        end
    endtask

    task automatic test_frame(input string name, input bit toggle, input int extra,
                              input logic exp_short, input logic exp_extra);
        int s_win, s_shift, s_fd;
        s_win = n_win;
        s_shift = n_shift;
        s_fd = n_fd;
        first_win_cyc = -1;
        repeat (3) tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        while (m_active) begin
            tick(1'b1, 1'b1);
            if (toggle && m_active) tick(1'b0, 1'b1);
        end
        for (int i = 0; i < extra; i++) tick(1'b1, 1'b1);
        repeat (PL + 4) tick(1'b0, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (n_shift - s_shift != H * V) begin
            n_bad++;
            $display("FAIL %s shift_count got=%0d want=%0d", name, n_shift - s_shift, H * V);
        end
        n_cmp++;
        if (n_win - s_win != 8) begin
            n_bad++;
            $display("FAIL %s win_count got=%0d want=8", name, n_win - s_win);
        end
        n_cmp++;
        if (first_cx != 2 || first_cy != 2 || first_win_cyc != acc44 + PL) begin
            n_bad++;
            $display("FAIL %s first_win got=(%0d,%0d)@%0d want=(2,2)@%0d",
                     name, first_cx, first_cy, first_win_cyc, acc44 + PL);
        end
        n_cmp++;
        if (last_cx != 5 || last_cy != 3) begin
            n_bad++;
            $display("FAIL %s last_win got=(%0d,%0d) want=(5,3)", name, last_cx, last_cy);
        end
        n_cmp++;
        if (n_fd - s_fd != 1 || fd_cyc != last_win_cyc + 1 || fd_cyc != last_acc + PL + 1) begin
            n_bad++;
            $display("FAIL %s frame_done got=%0d@%0d want=1@%0d",
                     name, n_fd - s_fd, fd_cyc, last_acc + PL + 1);
        end
        n_cmp++;
        if (fd_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s busy_at_done got=%b want=0", name, fd_busy);
        end
        n_cmp++;
        if ({err_short, err_extra} !== {exp_short, exp_extra}) begin
            n_bad++;
            $display("FAIL %s errors got=%b want=%b", name, {err_short, err_extra}, {exp_short, exp_extra});
        end
    endtask

    task automatic test_abort();
        int s_win, s_fd, s_shift;
        s_win = n_win;
        s_fd = n_fd;
        s_shift = n_shift;
        repeat (3) tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        repeat (20) tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        @(negedge clk);
        n_cmp++;
        if ({busy, err_short} !== 2'b01) begin
            n_bad++;
            $display("FAIL abort_state got busy/short=%b want=01", {busy, err_short});
        end
        tick(1'b0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (buf_clear !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_clear got=%b want=1", buf_clear);
        end
        repeat (6) tick(1'b0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (n_win != s_win || n_fd != s_fd || n_shift - s_shift != 20) begin
            n_bad++;
            $display("FAIL abort_counts got win=%0d fd=%0d shift=%0d want=0/0/20",
                     n_win - s_win, n_fd - s_fd, n_shift - s_shift);
        end
        test_frame("after_abort", 1'b0, 0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        int s_win;
        repeat (3) tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        while (!(mx == 5 && my == 4)) tick(1'b1, 1'b1);
        s_win = n_win;
        apply_reset(1'b1);
        @(negedge clk);
        n_cmp++;
        if ({shift_en, buf_clear, win_valid, busy, frame_done, err_short, err_extra} !== 7'b0100000) begin
            n_bad++;
            $display("FAIL midreset_flags got=%b want=0100000",
                     {shift_en, buf_clear, win_valid, busy, frame_done, err_short, err_extra});
        end
        n_cmp++;
        if (center_x !== '0 || center_y !== '0) begin
            n_bad++;
            $display("FAIL midreset_center got=(%0d,%0d) want=(0,0)", center_x, center_y);
        end
        reset = 1'b0;
        repeat (4) tick(1'b1, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (n_win != s_win || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_inflight got win=%0d busy=%b want=0/0", n_win - s_win, busy);
        end
        test_frame("after_reset", 1'b0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_idle_ignore();
        test_frame("full", 1'b0, 0, 1'b0, 1'b0);
        test_frame("toggle", 1'b1, 0, 1'b0, 1'b0);
        test_abort();
        test_frame("drain_extra", 1'b0, 2, 1'b1, 1'b1);
        test_reset_mid();
        repeat (4) tick(1'b0, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (wq.size() != 0 || sq.size() != 0) begin
            n_bad++;
            $display("FAIL leftover got win=%0d shift=%0d want=0/0", wq.size(), sq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
